output_slice_buffer: RTL and testbench



---
 rtl/output_slice_buffer.sv | 181 ++++++++++++++++++
 tb/tb_output_slice_buffer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_slice_buffer.sv
// output_slice_buffer
// Buffers wide activation words (N_DIM_ARRAY signed lanes of ACT_DATA_WIDTH
// bits, each with a base address) in a small FIFO. It then emits them as
// narrower OUT_LANES slices with per-slice addresses over a valid/ready port.
// Draining starts when occupancy reaches a mode-dependent threshold (full FIFO
// in CNN mode, FC_THRESHOLD otherwise) or on a flush pulse.
// Optional build macro OUTPUT_SLICE_BUFFER_DROP_CNT_EN adds a saturating
// 16-bit drop_cnt output that counts writes rejected while the FIFO is full.
module output_slice_buffer #(
  parameter int N_DIM_ARRAY    = 8,
  parameter int ACT_DATA_WIDTH = 8,
  parameter int OUT_LANES      = 4,
  parameter int DEPTH          = 8,
  parameter int FC_THRESHOLD   = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [2:0]                            mode,
  input  logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] input_word,
  input  logic [31:0]                           input_addr,
  input  logic                                  input_en,
  output logic                                  input_ready,
  input  logic                                  flush,
  output logic [OUT_LANES*ACT_DATA_WIDTH-1:0]   output_word,
  output logic [31:0]                           output_addr,
  output logic                                  output_en,
  input  logic                                  output_ready
`ifdef OUTPUT_SLICE_BUFFER_DROP_CNT_EN
  ,
  output logic [15:0]                           drop_cnt
`endif
);

  localparam int SLICES = N_DIM_ARRAY / OUT_LANES;
  localparam int IN_W   = N_DIM_ARRAY * ACT_DATA_WIDTH;
  localparam int OUT_W  = OUT_LANES * ACT_DATA_WIDTH;
  localparam int AW     = $clog2(DEPTH);
  localparam int OCC_W  = AW + 1;
  localparam int SW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_FC_THR = OCC_W'(FC_THRESHOLD);
  localparam logic [SW-1:0]    SLICE_LAST = SW'(SLICES - 1);
  localparam logic [31:0]      SLICES_32  = 32'(SLICES);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t           state;
  logic [IN_W-1:0]  mem_word [DEPTH];
  logic [31:0]      mem_addr [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [SW-1:0]    slice_cnt;
  logic             mode_cnn;

  logic             wr_acc;
  logic             out_fire;
  logic             last_slice;
  logic             rd_done;
  logic [OCC_W-1:0] occ_rd;
  logic [OCC_W-1:0] occ_nxt;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [SW-1:0]    slice_nxt;
  logic             bypass;
  logic [IN_W-1:0]  src_word;
  logic [31:0]      src_addr;
  logic [IN_W-1:0]  src_shift;
  logic [OUT_W-1:0] slice_word;
  logic [31:0]      slice_addr;
  logic             load;
  logic [OCC_W-1:0] threshold;
  logic             start_drain;

  assign input_ready = (occ != OCC_FULL);

  // Next-state datapath: handshakes, pointer/occupancy updates, and next slice.
  always_comb begin
    wr_acc      = input_en && input_ready;
    out_fire    = output_en && output_ready;
    last_slice  = (slice_cnt == SLICE_LAST);
    rd_done     = out_fire && last_slice;
    occ_rd      = occ - OCC_W'(rd_done);
    occ_nxt     = occ_rd + OCC_W'(wr_acc);
    rd_ptr_nxt  = rd_ptr + AW'(rd_done);
    slice_nxt   = slice_cnt;
    if (out_fire) begin
      slice_nxt = last_slice ? '0 : slice_cnt + SW'(1);
    end
    // When the only remaining entry is being written this very cycle, it is
    // not in the array yet, so it is taken straight from the input port.
    bypass      = (occ_rd == '0) && wr_acc;
    src_word    = bypass ? input_word : mem_word[rd_ptr_nxt];
    src_addr    = bypass ? input_addr : mem_addr[rd_ptr_nxt];
    src_shift   = src_word >> (OUT_W * slice_nxt);
    slice_word  = src_shift[OUT_W-1:0];
    slice_addr  = src_addr * SLICES_32 + 32'(slice_nxt);
    load        = (state == DRAIN) && (!output_en || out_fire);
    threshold   = mode_cnn ? OCC_FULL : OCC_FC_THR;
    start_drain = (occ >= threshold) || (flush && (occ != '0));
  end

  // Entry storage; holds data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_word[wr_ptr] <= input_word;
      mem_addr[wr_ptr] <= input_addr;
    end
  end

  // FIFO control: pointers, occupancy, and mode latched on a write into empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      mode_cnn <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      occ    <= occ_nxt;
      if (wr_acc && (occ == '0)) begin
        mode_cnn <= (mode == 3'd1);
      end
    end
  end

  // Drain FSM with registered slice outputs; output_word is zero while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      slice_cnt   <= '0;
      output_en   <= 1'b0;
      output_word <= '0;
      output_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_drain) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (load) begin
            if (occ_nxt == '0) begin
              state       <= IDLE;
              slice_cnt   <= '0;
              output_en   <= 1'b0;
              output_word <= '0;
              output_addr <= '0;
            end else begin
              slice_cnt   <= slice_nxt;
              output_en   <= 1'b1;
              output_word <= slice_word;
              output_addr <= slice_addr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OUTPUT_SLICE_BUFFER_DROP_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count writes rejected because the FIFO was full, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (input_en && !input_ready) begin
      drop_cnt <= sat_inc16(drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_output_slice_buffer.sv
// Scoreboard bench for output_slice_buffer: stimulus pushes hand-computed
// slices into a queue, and a negedge monitor compares every presented slice.
module tb_output_slice_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  mode;
  logic [63:0] input_word;
  logic [31:0] input_addr;
  logic        input_en;
  logic        input_ready;
  logic        flush;
  logic [31:0] output_word;
  logic [31:0] output_addr;
  logic        output_en;
  logic        output_ready;
`ifdef OUTPUT_SLICE_BUFFER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int          checks = 0;
  int          passed = 0;
  logic [63:0] exp_q[$];
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  output_slice_buffer #(
    .N_DIM_ARRAY(8), .ACT_DATA_WIDTH(8), .OUT_LANES(4), .DEPTH(8), .FC_THRESHOLD(2)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .input_word(input_word), .input_addr(input_addr), .input_en(input_en),
    .input_ready(input_ready), .flush(flush),
    .output_word(output_word), .output_addr(output_addr), .output_en(output_en),
    .output_ready(output_ready)
`ifdef OUTPUT_SLICE_BUFFER_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic push_slice(input logic [31:0] a, input logic [31:0] w);
    exp_q.push_back({a, w});
  endtask

  // Caller is positioned just after a rising edge; returns just after the next.
  task automatic do_write(input logic [63:0] w, input logic [31:0] a, input logic [2:0] m);
    input_word = w;
    input_addr = a;
    mode       = m;
    input_en   = 1'b1;
    @(posedge clk);
    #1;
    input_en   = 1'b0;
  endtask

  task automatic wait_drain(input string nm, output int n);
    n = 0;
    while ((exp_q.size() != 0 || output_en) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      $display("FAIL %s: drain timeout, %0d slices still expected", nm, exp_q.size());
    end
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!output_en && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!output_en) begin
      checks++;
      $display("FAIL %s: output_en never rose, got 0 expected 1", nm);
    end
  endtask

  // Monitor: compare the presented slice to the queue head; pop on acceptance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (output_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_slice: got addr %h word %h, expected no output", output_addr, output_word);
        end else begin
          check("slice_addr", 64'(output_addr), 64'(exp_q[0][63:32]));
          check("slice_word", 64'(output_word), 64'(exp_q[0][31:0]));
          if (output_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_word_zero", 64'(output_word), 64'h0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] kb;
    reset = 1'b0; mode = 3'd0; input_word = '0; input_addr = '0;
    input_en = 1'b0; flush = 1'b0; output_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_output_en", 64'(output_en), 64'h0);
    check("rst_output_word", 64'(output_word), 64'h0);
    check("rst_output_addr", 64'(output_addr), 64'h0);
    check("rst_input_ready", 64'(input_ready), 64'h1);
    reset = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // CNN: 8 writes, lanes all k, addr 16k; mode changes after the first are ignored
    for (int k = 0; k < 8; k++) begin
      kb = 8'(k);
      if (k == 7) begin
        repeat (3) @(posedge clk);
        #1;
        check("cnn_no_early_drain", 64'(output_en), 64'h0);
        check("cnn_ready_at_7", 64'(input_ready), 64'h1);
      end
      push_slice(32'(32 * k), {4{kb}});
      push_slice(32'(32 * k + 1), {4{kb}});
      do_write({8{kb}}, 32'(16 * k), (k == 0) ? 3'd1 : 3'd0);
    end
    check("cnn_full_ready", 64'(input_ready), 64'h0);
    wait_drain("cnn_drain", n);
    check("cnn_drain_cycles", 64'(n), 64'd18);

    // FC: two writes start a drain; address multiply wraps modulo 2^32
    push_slice(32'h0000_0200, 32'h4433_2211);
    push_slice(32'h0000_0201, 32'h8877_6655);
    push_slice(32'h0000_000A, 32'hDDCC_BBAA);
    push_slice(32'h0000_000B, 32'h1122_3344);
    do_write(64'h8877_6655_4433_2211, 32'h0000_0100, 3'd0);
    do_write(64'h1122_3344_DDCC_BBAA, 32'h8000_0005, 3'd0);
    wait_drain("fc2_drain", n);
    check("fc2_drain_cycles", 64'(n), 64'd6);

    // FC (mode 5): one write waits; a flush pulse drains it
    push_slice(32'h0000_000E, 32'hB0A0_9080);
    push_slice(32'h0000_000F, 32'hF0E0_D0C0);
    do_write(64'hF0E0_D0C0_B0A0_9080, 32'h0000_0007, 3'd5);
    repeat (3) @(posedge clk);
    #1;
    check("fc1_waits_below_thr", 64'(output_en), 64'h0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wait_drain("flush_drain", n);
    check("flush_drain_cycles", 64'(n), 64'd3);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("flush_empty_no_effect", 64'(output_en), 64'h0);

    // Backpressure: 3 stalled cycles after the first slice is accepted
    push_slice(32'h0000_0040, 32'h0403_0201);
    push_slice(32'h0000_0041, 32'h0807_0605);
    push_slice(32'h0000_0042, 32'h1413_1211);
    push_slice(32'h0000_0043, 32'h1817_1615);
    do_write(64'h0807_0605_0403_0201, 32'h0000_0020, 3'd0);
    do_write(64'h1817_1615_1413_1211, 32'h0000_0021, 3'd0);
    wait_valid("bp_valid");
    @(posedge clk);
    #1;
    output_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_output_en", 64'(output_en), 64'h1);
      check("stall_output_addr", 64'(output_addr), 64'h41);
    end
    @(posedge clk);
    #1;
    output_ready = 1'b1;
    wait_drain("bp_drain", n);

    // Write accepted in the same cycle as the final slice of the last entry
    push_slice(32'h0000_0060, 32'h1111_1111);
    push_slice(32'h0000_0061, 32'h2222_2222);
    push_slice(32'h0000_0062, 32'h3333_3333);
    push_slice(32'h0000_0063, 32'h4444_4444);
    do_write(64'h2222_2222_1111_1111, 32'h0000_0030, 3'd0);
    do_write(64'h4444_4444_3333_3333, 32'h0000_0031, 3'd0);
    n = 0;
    while (!(output_en && output_addr == 32'h63) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      $display("FAIL wr_on_final_wait: last slice addr 63 never presented, got addr %h", output_addr);
    end
    push_slice(32'h0000_0064, 32'h5555_5555);
    push_slice(32'h0000_0065, 32'h6666_6666);
    input_word = 64'h6666_6666_5555_5555;
    input_addr = 32'h0000_0032;
    mode       = 3'd0;
    input_en   = 1'b1;
    @(posedge clk);
    #1;
    input_en = 1'b0;
    check("wr_on_final_continue", 64'(output_en), 64'h1);
    check("wr_on_final_addr", 64'(output_addr), 64'h64);
    check("wr_on_final_ready", 64'(input_ready), 64'h1);
    wait_drain("wr_on_final_drain", n);

    // Full FIFO, downstream stalled: two extra writes are dropped
    output_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      kb = 8'(8'h40 + k);
      push_slice(32'(32'h2000 + 2 * k), {4{kb}});
      push_slice(32'(32'h2001 + 2 * k), {4{kb}});
      do_write({8{kb}}, 32'(32'h1000 + k), 3'd1);
    end
    check("full_ready_low", 64'(input_ready), 64'h0);
    wait_valid("full_valid");
    do_write(64'hDEAD_BEEF_DEAD_BEEF, 32'h0000_9999, 3'd1);
    do_write(64'hCAFE_F00D_CAFE_F00D, 32'h0000_9998, 3'd1);
    check("full_ready_still_low", 64'(input_ready), 64'h0);
`ifdef OUTPUT_SLICE_BUFFER_DROP_CNT_EN
    check("drop_cnt", 64'(drop_cnt), 64'd2);
`endif
    output_ready = 1'b1;
    wait_drain("full_drain", n);

    // Reset after 3 slices of a CNN drain, then an FC sequence
    output_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      kb = 8'(8'hA0 + k);
      push_slice(32'(32'hA0 + 2 * k), {4{kb}});
      push_slice(32'(32'hA1 + 2 * k), {4{kb}});
      do_write({8{kb}}, 32'(32'h50 + k), 3'd1);
    end
    wait_valid("rst_mid_valid");
    output_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    output_ready = 1'b0;
    check("rst_mid_remaining", 64'(exp_q.size()), 64'd13);
    exp_q.delete();
    #1;
    check("rst_mid_output_en", 64'(output_en), 64'h0);
    check("rst_mid_output_word", 64'(output_word), 64'h0);
    check("rst_mid_input_ready", 64'(input_ready), 64'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    output_ready = 1'b1;
    push_slice(32'h0000_000A, 32'h0B0A_0908);
    push_slice(32'h0000_000B, 32'h0F0E_0D0C);
    push_slice(32'hFFFF_FFFE, 32'h8080_8080);
    push_slice(32'hFFFF_FFFF, 32'h7F7F_7F7F);
    do_write(64'h0F0E_0D0C_0B0A_0908, 32'h0000_0005, 3'd0);
    do_write(64'h7F7F_7F7F_8080_8080, 32'hFFFF_FFFF, 3'd0);
    wait_drain("post_rst_drain", n);
    check("post_rst_drain_cycles", 64'(n), 64'd6);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
